hazard_stall_ctrl: RTL and testbench

- Pipeline sequencing controller for the 5-stage MIPS CPU.
- Detects hazards that operand forwarding cannot cover:
  - load-use
  - taken-branch redirect
  - multi-cycle multiply/divide occupancy in EX
- Drives the PC/IF-ID/ID-EX write enables and the bubble/flush controls that surround the forwarding paths.
- Sits beside the forwarding unit and the decode stage.

---
 rtl/hazard_stall_ctrl_pkg.sv | 26 ++
 rtl/hazard_stall_ctrl_mdu_busy_cnt.sv | 29 ++
 rtl/hazard_stall_ctrl.sv | 143 ++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared encodings, latency defaults and the load-use match helper for hazard_stall_ctrl.
// The optional HAZARD_STATS_EN counters are enabled in the top module.
package hazard_stall_ctrl_pkg;

  typedef enum logic {
    HZ_RUN    = 1'b0,
    HZ_MDBUSY = 1'b1
  } hz_state_e;

  localparam int MUL_LAT_DEF = 4;
  localparam int DIV_LAT_DEF = 32;
  localparam int CNT_W_DEF   = 6;

  // A load into $0 never creates a dependency; rt only counts when it feeds the ALU/branch.
  function automatic logic load_use_hit(
    input logic       ex_mem_read,
    input logic [4:0] ex_rt,
    input logic [4:0] id_rs,
    input logic [4:0] id_rt,
    input logic       id_rt_src
  );
    return ex_mem_read && (ex_rt != 5'd0) &&
           ((ex_rt == id_rs) || (id_rt_src && (ex_rt == id_rt)));
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_mdu_busy_cnt.sv
// Loadable down-counter with zero flag; tracks remaining EX occupancy of a mult/div.
module mdu_busy_cnt #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall/flush controller: load-use, taken-branch redirect and mult/div EX occupancy.
// Define HAZARD_STATS_EN to add the saturating StallCnt/FlushCnt outputs.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  IFIDRegRs,
  input  logic [4:0]  IFIDRegRt,
  input  logic        IFIDUsesRt,
  input  logic        IFIDMemWrite,
  input  logic        IDEXMemRead,
  input  logic [4:0]  IDEXRegRt,
  input  logic        IDEXMduStart,
  input  logic        IDEXMduIsDiv,
  input  logic        EXBranchTaken,
  output logic        PCWrite,
  output logic        IFIDWrite,
  output logic        IDEXWrite,
  output logic        IFIDFlush,
  output logic        IDEXFlush,
  output logic        EXMEMFlush,
  output logic        MduBusy,
  output logic        MduDone
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0] StallCnt,
  output logic [31:0] FlushCnt
`endif
);

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 2);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 2);

  hz_state_e        state_q, state_d;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt_val;
  logic [CNT_W-1:0] cnt_load_val;
  logic             rt_src;
  logic             lu_hit;

  // A store whose rt is only store data gets it from the MEM-stage forward instead.
  assign rt_src       = IFIDUsesRt & ~(IFIDMemWrite & ~IFIDUsesRt);
  assign lu_hit       = load_use_hit(IDEXMemRead, IDEXRegRt, IFIDRegRs, IFIDRegRt, rt_src);
  assign cnt_load_val = IDEXMduIsDiv ? DIV_LOAD : MUL_LOAD;

  mdu_busy_cnt #(.CNT_W(CNT_W)) u_busy_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .dec_i      (cnt_dec),
    .cnt_o      (cnt_val),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    state_d    = state_q;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    PCWrite    = 1'b0;
    IFIDWrite  = 1'b0;
    IDEXWrite  = 1'b0;
    IFIDFlush  = 1'b0;
    IDEXFlush  = 1'b0;
    EXMEMFlush = 1'b0;
    MduBusy    = 1'b0;
    MduDone    = 1'b0;
    if (!rst) begin
      case (state_q)
        HZ_RUN: begin
          PCWrite   = 1'b1;
          IFIDWrite = 1'b1;
          IDEXWrite = 1'b1;
          if (EXBranchTaken) begin
            IFIDFlush = 1'b1;
            IDEXFlush = 1'b1;
          end else if (IDEXMduStart) begin
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            IDEXWrite  = 1'b0;
            EXMEMFlush = 1'b1;
            MduBusy    = 1'b1;
            cnt_load   = 1'b1;
            state_d    = HZ_MDBUSY;
          end else if (lu_hit) begin
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
            IDEXFlush = 1'b1;
          end
        end
        HZ_MDBUSY: begin
          MduBusy = 1'b1;
          if (cnt_zero) begin
            // Result is captured into EX/MEM on this edge, so no bubble now.
            MduDone = 1'b1;
            state_d = HZ_RUN;
          end else begin
            EXMEMFlush = 1'b1;
            cnt_dec    = 1'b1;
          end
        end
        default: state_d = HZ_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HZ_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && (state_q == HZ_MDBUSY)) begin
      assert (cnt_val <= DIV_LOAD);
    end
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!PCWrite && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (IFIDFlush && (flush_cnt_q != 32'hFFFF_FFFF)) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign StallCnt = stall_cnt_q;
  assign FlushCnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: stimulus pushes expected output vectors, a negedge monitor pops and compares.
// Define HAZARD_STATS_EN to also check the statistics counters.
module tb_hazard_stall_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] IFIDRegRs, IFIDRegRt, IDEXRegRt;
  logic       IFIDUsesRt, IFIDMemWrite, IDEXMemRead, IDEXMduStart, IDEXMduIsDiv, EXBranchTaken;
  logic       PCWrite, IFIDWrite, IDEXWrite, IFIDFlush, IDEXFlush, EXMEMFlush, MduBusy, MduDone;
`ifdef HAZARD_STATS_EN
  logic [31:0] StallCnt, FlushCnt;
`endif

  always #5 clk = ~clk;

  hazard_stall_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .IFIDRegRs     (IFIDRegRs),
    .IFIDRegRt     (IFIDRegRt),
    .IFIDUsesRt    (IFIDUsesRt),
    .IFIDMemWrite  (IFIDMemWrite),
    .IDEXMemRead   (IDEXMemRead),
    .IDEXRegRt     (IDEXRegRt),
    .IDEXMduStart  (IDEXMduStart),
    .IDEXMduIsDiv  (IDEXMduIsDiv),
    .EXBranchTaken (EXBranchTaken),
    .PCWrite       (PCWrite),
    .IFIDWrite     (IFIDWrite),
    .IDEXWrite     (IDEXWrite),
    .IFIDFlush     (IFIDFlush),
    .IDEXFlush     (IDEXFlush),
    .EXMEMFlush    (EXMEMFlush),
    .MduBusy       (MduBusy),
    .MduDone       (MduDone)
`ifdef HAZARD_STATS_EN
    ,
    .StallCnt      (StallCnt),
    .FlushCnt      (FlushCnt)
`endif
  );

  // Output vector order: {PCWrite, IFIDWrite, IDEXWrite, IFIDFlush, IDEXFlush, EXMEMFlush, MduBusy, MduDone}
  localparam logic [7:0] E_RST  = 8'b000_000_00;
  localparam logic [7:0] E_RUN  = 8'b111_000_00;
  localparam logic [7:0] E_LU   = 8'b001_010_00;
  localparam logic [7:0] E_BR   = 8'b111_110_00;
  localparam logic [7:0] E_BUSY = 8'b000_001_10;
  localparam logic [7:0] E_DONE = 8'b000_000_11;

  typedef struct {
    logic [7:0] exp;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  int   tests  = 0;
  int   fails  = 0;

  task automatic drive(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                       input logic uses_rt, input logic mw, input logic mr,
                       input logic [4:0] ex_rt, input logic start, input logic is_div,
                       input logic br, input logic [7:0] exp, input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; IFIDRegRs = rs; IFIDRegRt = rt; IFIDUsesRt = uses_rt; IFIDMemWrite = mw;
    IDEXMemRead = mr; IDEXRegRt = ex_rt; IDEXMduStart = start; IDEXMduIsDiv = is_div;
    EXBranchTaken = br;
    e.exp = exp;
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic idle(input logic [7:0] exp, input string tag);
    drive(1'b0, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, exp, tag);
  endtask

  // Monitor: combinational outputs settle mid-cycle; compare at the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        exp_t e;
        logic [7:0] act;
        e   = exp_q.pop_front();
        act = {PCWrite, IFIDWrite, IDEXWrite, IFIDFlush, IDEXFlush, EXMEMFlush, MduBusy, MduDone};
        tests++;
        if (act !== e.exp) begin
          fails++;
          $display("FAIL %s: got %b expected %b", e.tag, act, e.exp);
        end else begin
          $display("ok   %s: %b", e.tag, act);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; IFIDRegRs = '0; IFIDRegRt = '0; IFIDUsesRt = 1'b0; IFIDMemWrite = 1'b0;
    IDEXMemRead = 1'b0; IDEXRegRt = '0; IDEXMduStart = 1'b0; IDEXMduIsDiv = 1'b0;
    EXBranchTaken = 1'b0;

    // Reset holds every output low regardless of hazard inputs.
    drive(1'b1, 5'd8, 5'd2, 1'b1, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, E_RST, "rst_loaduse_in");
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, E_RST, "rst_branch_mdu_in");
    idle(E_RUN, "run_defaults");

    // lw $8 ; add $9,$8,$2 -> one bubble, then ID/EX holds the bubble.
    drive(1'b0, 5'd8, 5'd2, 1'b1, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, E_LU, "lu_rs");
    drive(1'b0, 5'd8, 5'd2, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, E_RUN, "lu_rs_after");
    drive(1'b0, 5'd3, 5'd8, 1'b1, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, E_LU, "lu_rt_src");
    drive(1'b0, 5'd3, 5'd8, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, E_RUN, "store_data_no_stall");
    drive(1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, E_RUN, "lw_r0_no_stall");
    drive(1'b0, 5'd31, 5'd4, 1'b1, 1'b0, 1'b1, 5'd31, 1'b0, 1'b0, 1'b0, E_LU, "lu_r31");
    drive(1'b0, 5'd5, 5'd6, 1'b1, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, E_RUN, "lw_no_match");

    // Branch wins over load-use and over an MDU start.
    drive(1'b0, 5'd8, 5'd2, 1'b1, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b1, E_BR, "branch_over_lu");
    drive(1'b0, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, E_BR, "branch_over_mdu");
    idle(E_RUN, "branch_mdu_ignored");

    // mult: 4-cycle freeze, busy inputs ignored, then load-use evaluated afterwards.
    drive(1'b0, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, E_BUSY, "mul_c1");
    drive(1'b0, 5'd8, 5'd2, 1'b1, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b1, E_BUSY, "mul_c2_ign");
    idle(E_BUSY, "mul_c3");
    drive(1'b0, 5'd8, 5'd2, 1'b1, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, E_DONE, "mul_c4_done");
    drive(1'b0, 5'd8, 5'd2, 1'b1, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, E_LU, "lu_after_mdu");
    idle(E_RUN, "run_after_mul");

    // Full divide: 32-cycle freeze.
    drive(1'b0, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, E_BUSY, "div_c1");
    for (int i = 2; i < 32; i++) idle(E_BUSY, $sformatf("div_c%0d", i));
    idle(E_DONE, "div_c32_done");
    idle(E_RUN, "run_after_div");

    // Divide aborted by reset in busy cycle 10.
    drive(1'b0, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, E_BUSY, "divab_c1");
    for (int i = 2; i < 10; i++) idle(E_BUSY, $sformatf("divab_c%0d", i));
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, E_RST, "divab_c10_rst");
    idle(E_RUN, "divab_run");
    idle(E_RUN, "divab_run2");

`ifdef HAZARD_STATS_EN
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, E_RST, "stats_rst");
    drive(1'b0, 5'd8, 5'd2, 1'b1, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, E_LU, "stats_lu");
    idle(E_RUN, "stats_lu_after");
    drive(1'b0, 5'd8, 5'd2, 1'b1, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b1, E_BR, "stats_br");
    drive(1'b0, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, E_BUSY, "stats_mul_c1");
    idle(E_BUSY, "stats_mul_c2");
    idle(E_BUSY, "stats_mul_c3");
    idle(E_DONE, "stats_mul_c4");
    idle(E_RUN, "stats_tail");
    tests++;
    if (StallCnt !== 32'd5) begin
      fails++;
      $display("FAIL stall_cnt: got %0d expected 5", StallCnt);
    end else $display("ok   stall_cnt: %0d", StallCnt);
    tests++;
    if (FlushCnt !== 32'd1) begin
      fails++;
      $display("FAIL flush_cnt: got %0d expected 1", FlushCnt);
    end else $display("ok   flush_cnt: %0d", FlushCnt);
`endif

    // Let the monitor drain the scoreboard (bounded).
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    @(posedge clk);
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
